// File: rtl/store_buffer_pkg.sv
// Shared constants, width derivations and the default-width entry layout for
// the store buffer.
package store_buffer_pkg;

  localparam int SB_DATA_W = 32;
  localparam int SB_ADDR_W = 32;
  localparam int SB_DEPTH  = 4;

  function automatic int sb_strb_w(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int sb_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int sb_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int SB_STRB_W = sb_strb_w(SB_DATA_W);
  localparam int SB_PTR_W  = sb_ptr_w(SB_DEPTH);
  localparam int SB_CNT_W  = sb_cnt_w(SB_DEPTH);

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
    logic [SB_STRB_W-1:0] strb;
    logic                 wr;
    logic                 valid;
  } sb_entry_t;

endpackage

// File: rtl/sb_youngest_sel.sv
// Priority selector: finds the youngest set bit of a match vector, searching
// backward from head-1 around the ring.
module sb_youngest_sel #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] match_i,
  input  logic [PTR_W-1:0] head_i,
  output logic [PTR_W-1:0] idx_o,
  output logic             hit_o
);

  logic [PTR_W-1:0] cand;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path holds state (no latch).
    hit_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    // k=DEPTH truncates to 0, so the last candidate checked is head itself.
    for (int k = 1; k <= DEPTH; k++) begin
      cand = head_i - PTR_W'(k);
      if (!hit_o && match_i[cand]) begin
        hit_o = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store/load buffer with a combinational read-after-write lookup that
// forwards data from the youngest matching store.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter  int DATA_W = SB_DATA_W,
  parameter  int ADDR_W = SB_ADDR_W,
  parameter  int DEPTH  = SB_DEPTH,
  localparam int STRB_W = sb_strb_w(DATA_W),
  localparam int PTR_W  = sb_ptr_w(DEPTH),
  localparam int CNT_W  = sb_cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [ADDR_W-1:0] enq_addr,
  input  logic [DATA_W-1:0] enq_data,
  input  logic [STRB_W-1:0] enq_strb,
  input  logic              enq_wr,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [ADDR_W-1:0] deq_addr,
  output logic [DATA_W-1:0] deq_data,
  output logic [STRB_W-1:0] deq_strb,
  output logic              deq_wr,
  input  logic [ADDR_W-1:0] lk_addr,
  input  logic [STRB_W-1:0] lk_strb,
  output logic              lk_hit,
  output logic              lk_full,
  output logic [DATA_W-1:0] lk_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              wr;
    logic              valid;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             enq_fire, deq_fire;
  logic [DEPTH-1:0] match;
  logic [PTR_W-1:0] sel_idx;
  logic             sel_hit;
  entry_t           sel_entry;
  entry_t           tail_entry;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign enq_ready = !full;
  assign deq_valid = !empty;
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_fire  = deq_valid && deq_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq_fire) head_d = head_q + PTR_W'(1);
    if (deq_fire) tail_d = tail_q + PTR_W'(1);
    case ({enq_fire, deq_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      // NOTE: payload storage is cleared too, so deq_* and lk_data read zero after reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      // Both firing implies neither full nor empty, so head != tail here.
      if (deq_fire) mem_q[tail_q].valid <= 1'b0;
      if (enq_fire) mem_q[head_q] <= '{addr: enq_addr, data: enq_data, strb: enq_strb,
                                        wr: enq_wr, valid: 1'b1};
    end
  end

  assign tail_entry = mem_q[tail_q];
  assign deq_addr   = tail_entry.addr;
  assign deq_data   = tail_entry.data;
  assign deq_strb   = tail_entry.strb;
  assign deq_wr     = tail_entry.wr;

  // Word-granular match; loads never forward.
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = mem_q[i].valid && mem_q[i].wr &&
                 (mem_q[i].addr[ADDR_W-1:2] == lk_addr[ADDR_W-1:2]);
    end
  end

  sb_youngest_sel #(.DEPTH(DEPTH)) u_sel (
    .match_i (match),
    .head_i  (head_q),
    .idx_o   (sel_idx),
    .hit_o   (sel_hit)
  );

  assign sel_entry = mem_q[sel_idx];
  assign lk_hit    = sel_hit;
  assign lk_full   = sel_hit && ((sel_entry.strb & lk_strb) == lk_strb);
  assign lk_data   = sel_hit ? sel_entry.data : '0;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios with literal
// expectations plus randomized traffic compared against a queue model.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int D  = 4;
  localparam int SW = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          enq_valid, enq_ready, enq_wr;
  logic [AW-1:0] enq_addr;
  logic [DW-1:0] enq_data;
  logic [SW-1:0] enq_strb;
  logic          deq_valid, deq_ready, deq_wr;
  logic [AW-1:0] deq_addr;
  logic [DW-1:0] deq_data;
  logic [SW-1:0] deq_strb;
  logic [AW-1:0] lk_addr;
  logic [SW-1:0] lk_strb;
  logic          lk_hit, lk_full;
  logic [DW-1:0] lk_data;
  logic [CW-1:0] count;
  logic          empty, full;

  store_buffer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_addr(enq_addr),
    .enq_data(enq_data), .enq_strb(enq_strb), .enq_wr(enq_wr),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_addr(deq_addr),
    .deq_data(deq_data), .deq_strb(deq_strb), .deq_wr(deq_wr),
    .lk_addr(lk_addr), .lk_strb(lk_strb), .lk_hit(lk_hit), .lk_full(lk_full),
    .lk_data(lk_data), .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the buffer is a plain queue, oldest at index 0.
  sb_entry_t mq[$];
  bit        model_clean = 1'b0;
  bit        model_live  = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      model_clean = 1'b1;
      model_live  = 1'b1;
    end else if (model_live) begin
      bit e, d;
      e = enq_valid && (mq.size() < D);
      d = deq_ready && (mq.size() > 0);
      if (d) void'(mq.pop_front());
      if (e) begin
        mq.push_back(sb_entry_t'{addr: enq_addr, data: enq_data, strb: enq_strb,
                                 wr: enq_wr, valid: 1'b1});
        model_clean = 1'b0;
      end
    end
  end

  function automatic void model_lookup(output bit hit, output bit fl, output logic [DW-1:0] data);
    hit  = 1'b0;
    fl   = 1'b0;
    data = '0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].wr && (mq[i].addr[AW-1:2] == lk_addr[AW-1:2])) begin
        hit  = 1'b1;
        data = mq[i].data;
        fl   = ((mq[i].strb & lk_strb) == lk_strb);
        break;
      end
    end
  endfunction

  // Compare process: every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (model_live) begin
      bit            m_hit, m_full;
      logic [DW-1:0] m_data;
      check("count",     64'(count),     64'(mq.size()));
      check("empty",     64'(empty),     64'(mq.size() == 0));
      check("full",      64'(full),      64'(mq.size() == D));
      check("enq_ready", 64'(enq_ready), 64'(mq.size() < D));
      check("deq_valid", 64'(deq_valid), 64'(mq.size() > 0));
      if (mq.size() > 0) begin
        check("deq_addr", 64'(deq_addr), 64'(mq[0].addr));
        check("deq_data", 64'(deq_data), 64'(mq[0].data));
        check("deq_strb", 64'(deq_strb), 64'(mq[0].strb));
        check("deq_wr",   64'(deq_wr),   64'(mq[0].wr));
      end else if (model_clean) begin
        check("deq_payload_zero", {deq_addr, deq_data}, 64'd0);
        check("deq_strb_zero", 64'({deq_strb, deq_wr}), 64'd0);
      end
      model_lookup(m_hit, m_full, m_data);
      check("lk_hit",  64'(lk_hit),  64'(m_hit));
      check("lk_full", 64'(lk_full), 64'(m_full));
      check("lk_data", 64'(lk_data), 64'(m_data));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    enq_addr  = '0;
    enq_data  = '0;
    enq_strb  = '0;
    enq_wr    = 1'b0;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [SW-1:0] s, input logic w);
    enq_addr  = a;
    enq_data  = d;
    enq_strb  = s;
    enq_wr    = w;
    enq_valid = 1'b1;
    step();
    enq_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return AW'(32'h100 + ($urandom_range(0, 3) * 4) + $urandom_range(0, 3));
  endfunction

  initial begin
    int sent, recv;
    idle();
    reset   = 1'b1;
    lk_addr = '0;
    lk_strb = '0;
    step();
    step();
    reset = 1'b0;
    #1;
    check("rst_count",     64'(count),     64'd0);
    check("rst_enq_ready", 64'(enq_ready), 64'd1);
    check("rst_deq_valid", 64'(deq_valid), 64'd0);
    check("rst_empty",     64'(empty),     64'd1);
    check("rst_lk_data",   64'(lk_data),   64'd0);
    check("rst_deq_data",  64'(deq_data),  64'd0);

    // Fill with four back-to-back stores.
    for (int i = 0; i < D; i++) push(AW'(32'h10 + 4 * i), DW'(32'h1000 + i), 4'hF, 1'b1);
    check("fill_full",      64'(full),      64'd1);
    check("fill_count",     64'(count),     64'd4);
    check("fill_enq_ready", 64'(enq_ready), 64'd0);

    // Full with both sides active: only the dequeue happens.
    enq_addr  = 32'h98;
    enq_data  = 32'hDEAD_BEEF;
    enq_strb  = 4'hF;
    enq_wr    = 1'b1;
    enq_valid = 1'b1;
    deq_ready = 1'b1;
    step();
    idle();
    lk_addr = 32'h98;
    lk_strb = 4'hF;
    #1;
    check("full_both_count",   64'(count),    64'd3);
    check("full_both_deqaddr", 64'(deq_addr), 64'h14);
    check("full_both_rejected", 64'(lk_hit),  64'd0);

    // Reset with three entries buffered.
    do_reset();
    lk_addr = 32'h18;
    #1;
    check("rst3_count", 64'(count),  64'd0);
    check("rst3_empty", 64'(empty),  64'd1);
    check("rst3_lk_hit", 64'(lk_hit), 64'd0);

    // Youngest store forwards; partial coverage reports a stall.
    push(32'h100, 32'hAAAA_AAAA, 4'hF, 1'b1);
    push(32'h100, 32'h5555_5555, 4'h3, 1'b1);
    lk_addr = 32'h102;
    lk_strb = 4'h3;
    #1;
    check("raw_hit",  64'(lk_hit),  64'd1);
    check("raw_full", 64'(lk_full), 64'd1);
    check("raw_data", 64'(lk_data), 64'h5555_5555);
    lk_strb = 4'hC;
    #1;
    check("raw_part_hit",  64'(lk_hit),  64'd1);
    check("raw_part_full", 64'(lk_full), 64'd0);
    lk_strb = 4'h0;
    #1;
    check("raw_zero_strb_full", 64'(lk_full), 64'd1);

    // Loads never match.
    do_reset();
    push(32'h200, 32'h1234_5678, 4'hF, 1'b0);
    lk_addr = 32'h200;
    lk_strb = 4'hF;
    #1;
    check("load_hit",  64'(lk_hit),  64'd0);
    check("load_data", 64'(lk_data), 64'd0);

    // Stream ten entries through so both pointers wrap.
    do_reset();
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 40 && recv < 10; cyc++) begin
      enq_valid = (sent < 10);
      enq_addr  = AW'(32'h300 + 4 * sent);
      enq_data  = DW'(32'hC000 + sent);
      enq_strb  = 4'hF;
      enq_wr    = 1'b1;
      deq_ready = 1'b1;
      #1;
      if (deq_valid) begin
        check("wrap_order", 64'(deq_data), 64'(32'hC000 + recv));
        recv++;
      end
      if (enq_valid && enq_ready) sent++;
      step();
    end
    idle();
    check("wrap_all_received", 64'(recv), 64'd10);

    // Randomized traffic, alternating fill-biased and drain-biased phases.
    for (int i = 0; i < 3000; i++) begin
      bit drain;
      drain     = ((i / 300) % 2) == 1;
      reset     = ($urandom_range(0, 99) == 0);
      enq_valid = ($urandom_range(0, 2) != 0);
      enq_addr  = rand_addr();
      enq_data  = $urandom;
      enq_strb  = SW'($urandom_range(0, 15));
      enq_wr    = ($urandom_range(0, 3) != 0);
      deq_ready = drain ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 2) == 0);
      lk_addr   = rand_addr();
      lk_strb   = SW'($urandom_range(0, 15));
      step();
    end
    reset = 1'b0;
    idle();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DATA_W, default 32, entry data width; multiple of 8.
REQ-002 Parameter ADDR_W, default 32, entry address width.
REQ-003 Parameter DEPTH, default 4, number of entries; power of two, >= 2.
REQ-004 Derived constants: STRB_W = DATA_W/8; PTR_W = clog2(DEPTH); CNT_W = PTR_W+1.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock for all state.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 enq_valid  in  1  producer offers an entry.
REQ-009 enq_ready  out  1  buffer accepts the entry this cycle.
REQ-010 enq_addr / enq_data / enq_strb / enq_wr  in  ADDR_W / DATA_W / STRB_W / 1  entry payload; wr=1 store, wr=0 load.
REQ-011 deq_valid  out  1  oldest entry available.
REQ-012 deq_ready  in  1  consumer takes the oldest entry.
REQ-013 deq_addr / deq_data / deq_strb / deq_wr  out  ADDR_W / DATA_W / STRB_W / 1  oldest entry payload.
REQ-014 lk_addr / lk_strb  in  ADDR_W / STRB_W  RAW lookup query (address, bytes needed).
REQ-015 lk_hit  out  1  some valid store entry matches lk_addr.
REQ-016 lk_full  out  1  youngest matching store covers every byte in lk_strb.
REQ-017 lk_data  out  DATA_W  data of youngest matching store.
REQ-018 count  out  CNT_W  occupied entries, 0..DEPTH.
REQ-019 empty / full  out  1 / 1  count==0 / count==DEPTH.

Function
REQ-020 Enqueue fires when enq_valid && enq_ready; enq_ready = !full; no bypass when full even if deq fires the same cycle.
REQ-021 Dequeue fires when deq_valid && deq_ready; deq_valid = !empty; no fall-through: an entry enqueued in cycle N is dequeuable at N+1 earliest.
REQ-022 deq_* present the entry at tail combinationally; payload is held stable until dequeue fires.
REQ-023 head/tail pointers PTR_W bits, wrap DEPTH-1 -> 0 on their own fire.
REQ-024 count: +1 on enqueue only, -1 on dequeue only, unchanged on both or neither.
REQ-025 Dequeue clears the tail entry's valid bit; enqueue sets head entry valid and writes payload.
REQ-026 Lookup is combinational over valid entries only; an entry enqueued this cycle is not visible until next cycle; an entry dequeued this cycle is still visible this cycle.
REQ-027 Match: valid && wr && enq-stored addr[ADDR_W-1:2] == lk_addr[ADDR_W-1:2]; loads never match.
REQ-028 Youngest match = first match searching from head-1 backward toward tail, modulo DEPTH.
REQ-029 lk_full = lk_hit && ((youngest.strb & lk_strb) == lk_strb); lk_hit && !lk_full means requester must stall.
REQ-030 lk_data = youngest match data; all-zero when lk_hit=0.
REQ-031 lk_strb==0 with a match yields lk_hit=1, lk_full=1.

Reset
REQ-032 reset forces head=0, tail=0, count=0, all valid bits=0, all payload storage=0.
REQ-033 After reset: enq_ready=1, deq_valid=0, empty=1, full=0, count=0, lk_hit=0, lk_full=0, lk_data=0, deq_* payload=0.
REQ-034 reset dominates any same-cycle enqueue/dequeue; in-flight entries are discarded.

Structure
REQ-035 A shared package holds STRB_W/PTR_W/CNT_W derivation and the entry struct (addr, data, strb, wr, valid).
REQ-036 One sub-module, sb_youngest_sel: parametrised priority selector returning youngest-match index and hit from a DEPTH-bit match vector and head pointer.

Verification
REQ-037 Reset, then enqueue 4 stores back-to-back, DEPTH=4 -> full=1, count=4, enq_ready=0 on cycle after 4th.
REQ-038 Full, enq_valid=1 and deq_ready=1 same cycle -> one dequeue only, count=3, offered entry not accepted.
REQ-039 Store 0x100 data 0xAAAA_AAAA strb 0xF, then store 0x100 data 0x5555_5555 strb 0x3; lookup 0x102 strb 0x3 -> hit=1, full=1, data=0x5555_5555; lookup strb 0xC -> hit=1, full=0.
REQ-040 Load entry at 0x200 only; lookup 0x200 -> lk_hit=0, lk_data=0.
REQ-041 Enqueue/dequeue 10 entries with DEPTH=4 -> pointers wrap, FIFO order preserved, deq_data matches enqueue order.
REQ-042 Assert reset with count=3 -> next cycle count=0, empty=1, lk_hit=0 for previously buffered addresses.
